instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, which is the first instruction-memory byte address issued after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the field bundle is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a bundle this cycle.
REQ-006 The block SHALL have port op_type, input, 3 bits: 0=R, 1=load, 2=I-ALU, 3=store, 4=branch; 5-7 are illegal.
REQ-007 The block SHALL have ports rd, rs1 and rs2, input, 5 bits each: register indices.
REQ-008 The block SHALL have ports funct3 (input, 3 bits) and funct7 (input, 7 bits); funct7 is used for R-type only.
REQ-009 The block SHALL have port imm, input, 32 bits: the signed byte immediate or offset.
REQ-010 The block SHALL have port out_valid, output, 1 bit: instr, addr and err are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream (instruction-memory writer) accepts.
REQ-012 The block SHALL have port instr, output, 32 bits: the encoded RV32I instruction word.
REQ-013 The block SHALL have port addr, output, 32 bits: the word-aligned write address for instr.
REQ-014 The block SHALL have port err, output, 1 bit: the current instr had an illegal op_type or an out-of-range immediate.
REQ-015 The block SHALL have port err_cnt, output, 8 bits: a saturating count of emitted words with err=1.

Function
REQ-016 The FSM SHALL have the states IDLE, ENCODE and HOLD; in_ready=1 only in IDLE; out_valid=1 only in HOLD.
REQ-017 In IDLE, when in_valid=1 the block SHALL register all input fields and go to ENCODE; otherwise it stays in IDLE.
REQ-018 ENCODE SHALL register instr and err, then go to HOLD unconditionally, so out_valid rises exactly 2 cycles after the accepting edge.
REQ-019 In HOLD, when out_ready=1 the block SHALL advance addr by 4, increment err_cnt if err=1, and go to IDLE; while out_ready=0, instr, addr and err SHALL remain stable.
REQ-020 Opcodes SHALL be: R=0110011, load=0000011, I-ALU=0010011, store=0100011, branch=1100011.
REQ-021 R-type SHALL be encoded as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-022 Load and I-ALU SHALL be encoded as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-023 Store SHALL be encoded as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-024 Branch SHALL be encoded as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-025 Range check: for load, I-ALU and store, err=1 if imm is outside -2048..2047; for branch, err=1 if imm is outside -4096..4094 or imm[0]=1; R-type never flags an immediate error.
REQ-026 When a range error occurs, the word SHALL still be emitted using the truncated imm bits as above.
REQ-027 An illegal op_type SHALL produce instr=32'h0000_0013 (nop) with err=1.
REQ-028 addr SHALL wrap modulo 2^32 with no flag; err_cnt SHALL saturate at 255.
REQ-029 A new bundle is never accepted while in ENCODE or HOLD (one bundle in flight, no overlap).

Reset
REQ-030 While reset=1 the block SHALL hold: state=IDLE, in_ready=1, out_valid=0, instr=0, err=0, err_cnt=0, addr=BASE_ADDR.
REQ-031 Reset asserted in ENCODE or HOLD SHALL drop the in-flight bundle without advancing addr or err_cnt.

Verification
REQ-032 The bench SHALL apply op_type=2, rd=1, rs1=0, funct3=0, imm=5 and check -> instr=0x00500093, err=0, addr=BASE_ADDR, out_valid 2 cycles after acceptance.
REQ-033 The bench SHALL apply op_type=1, rd=2, rs1=1, funct3=2, imm=8, then op_type=3, rs1=1, rs2=2, funct3=2, imm=12, and check -> 0x0080A103 at addr 0, then 0x0020A623 at addr 4.
REQ-034 The bench SHALL apply op_type=4, rs1=1, rs2=2, funct3=0, imm=-8 and check -> instr=0xFE208CE3, err=0; the same with imm=-7 -> err=1 and err_cnt incremented.
REQ-035 The bench SHALL apply op_type=2, rd=1, rs1=0, imm=2048 and check -> instr=0x80000093, err=1; op_type=6 -> instr=0x00000013, err=1.
REQ-036 The bench SHALL hold out_ready=0 for 3 cycles in HOLD and check -> instr, addr and err unchanged, in_ready=0; on release, addr advances by exactly 4.
REQ-037 The bench SHALL assert reset in HOLD after two accepted words and check -> addr=BASE_ADDR, err_cnt=0, out_valid=0 asynchronously, with the next word emitted at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: captures a field bundle, encodes it into a
// 32-bit instruction word and presents it with a sequential write address.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ADDR_INC = 4;

  localparam logic [2:0] OP_R      = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_IALU   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_encode;
  logic              w_retire;

  logic              r_in_ready;
  logic              r_out_valid;

  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  logic [XLEN-1:0]   r_imm;

  logic [XLEN-1:0]   r_instr;
  logic              r_err;
  logic [XLEN-1:0]   r_addr;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [XLEN-1:0]   w_instr;
  logic              w_err;
  logic              w_imm12_ok;
  logic              w_imm13_ok;

  // Next-state and handshake strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_encode    = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ENCODE;
        end
      end
      S_ENCODE: begin
        w_encode    = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with registered handshake outputs decoded from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_HOLD);
    end
  end

  // Capture the input bundle on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_funct3 <= '0;
      r_funct7 <= '0;
      r_imm    <= '0;
    end else if (w_accept) begin
      r_op     <= op_type;
      r_rd     <= rd;
      r_rs1    <= rs1;
      r_rs2    <= rs2;
      r_funct3 <= funct3;
      r_funct7 <= funct7;
      r_imm    <= imm;
    end
  end

  // Signed range checks: 12-bit immediate, and 13-bit even branch offset
  assign w_imm12_ok = (&r_imm[31:11]) | ~(|r_imm[31:11]);
  assign w_imm13_ok = ((&r_imm[31:12]) | ~(|r_imm[31:12])) & ~r_imm[0];

  // Instruction word formatting; illegal op types become a flagged nop
  always_comb begin
    w_instr = NOP_WORD;
    w_err   = 1'b1;
    case (r_op)
      OP_R: begin
        w_instr = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, OPC_R};
        w_err   = 1'b0;
      end
      OP_LOAD: begin
        w_instr = {r_imm[11:0], r_rs1, r_funct3, r_rd, OPC_LOAD};
        w_err   = ~w_imm12_ok;
      end
      OP_IALU: begin
        w_instr = {r_imm[11:0], r_rs1, r_funct3, r_rd, OPC_IALU};
        w_err   = ~w_imm12_ok;
      end
      OP_STORE: begin
        w_instr = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], OPC_STORE};
        w_err   = ~w_imm12_ok;
      end
      OP_BRANCH: begin
        w_instr = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                   r_imm[4:1], r_imm[11], OPC_BRANCH};
        w_err   = ~w_imm13_ok;
      end
      default: begin
        w_instr = NOP_WORD;
        w_err   = 1'b1;
      end
    endcase
  end

  // Result registers, loaded once per bundle and held through HOLD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_err   <= 1'b0;
    end else if (w_encode) begin
      r_instr <= w_instr;
      r_err   <= w_err;
    end
  end

  // Write address advances per retired word and wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= BASE_ADDR;
    end else if (w_retire) begin
      r_addr <= r_addr + XLEN'(ADDR_INC);
    end
  end

  // Saturating count of retired words that carried an error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_retire && r_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign instr     = r_instr;
  assign addr      = r_addr;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule
